echo_sample_frontend: RTL and testbench

//  Upstream feeder for the NLMS echo approximation stage. Captures one far-end and one near-end

---
 rtl/echo_pkg.sv | 18 +
 rtl/pcm_to_double.sv | 58 +++++
 rtl/echo_sample_frontend.sv | 114 +++++++++++
 tb/tb_echo_sample_frontend.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/echo_pkg.sv
// Shared types and constants for the echo sample frontend: FSM state encoding
// and the IEEE-754 double-precision constants used by the PCM converter.
package echo_pkg;

  localparam int DOUBLE_W = 64;
  localparam int EXP_BIAS = 1023;
  localparam logic [DOUBLE_W-1:0] FP_ZERO = 64'h0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONVERT,
    ST_BUFFER,
    ST_PRESENT,
    ST_WAIT_LO,
    ST_WAIT_HI
  } state_t;

endpackage

// File: rtl/pcm_to_double.sv
// Sequential signed-PCM to IEEE-754 double converter. One normalising shift per
// cycle; done always fires on the PCM_W-th cycle after start, whatever the input.
module pcm_to_double
  import echo_pkg::*;
#(
  parameter int PCM_W = 16
) (
  input  logic                clk_operation,
  input  logic                rst,
  input  logic                start,
  input  logic [PCM_W-1:0]    pcm,
  output logic                done,
  output logic [DOUBLE_W-1:0] result
);

  localparam int SH_W  = $clog2(PCM_W + 1);
  localparam int CNT_W = $clog2(PCM_W);

  logic [PCM_W:0]   mag;
  logic [PCM_W:0]   pcm_ext;
  logic [SH_W-1:0]  shifts;
  logic [CNT_W-1:0] cnt;
  logic             neg;
  logic             running;
  logic [10:0]      exp_field;

  // One extra magnitude bit keeps the most negative code exact after negation.
  assign pcm_ext = {pcm[PCM_W-1], pcm};

  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      mag     <= '0;
      shifts  <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      running <= 1'b0;
    end else if (start) begin
      mag     <= pcm[PCM_W-1] ? -pcm_ext : pcm_ext;
      shifts  <= '0;
      cnt     <= '0;
      neg     <= pcm[PCM_W-1];
      running <= 1'b1;
    end else if (running) begin
      if (!mag[PCM_W] && (mag != '0)) begin
        mag    <= mag << 1;
        shifts <= shifts + SH_W'(1);
      end
      cnt <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(PCM_W - 1)) running <= 1'b0;
    end
  end

  assign done      = running && (cnt == CNT_W'(PCM_W - 1));
  assign exp_field = 11'(EXP_BIAS + PCM_W) - 11'(shifts);
  assign result    = (mag == '0) ? FP_ZERO
                   : {neg, exp_field, mag[PCM_W-1:0], {(52 - PCM_W){1'b0}}};

endmodule

// File: rtl/echo_sample_frontend.sv
// Converts far/near PCM samples to doubles, delays the near-end value through an
// alignment buffer, then hands both to the echo approximator with a start pulse.
module echo_sample_frontend
  import echo_pkg::*;
#(
  parameter int PCM_W     = 16,
  parameter int MAX_DELAY = 64,
  parameter int DELAY_W   = 6
) (
  input  logic                clk_operation,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [PCM_W-1:0]    far_pcm,
  input  logic [PCM_W-1:0]    near_pcm,
  input  logic [DELAY_W-1:0]  delay,
  input  logic                approx_ready,
  output logic [DOUBLE_W-1:0] signal,
  output logic [DOUBLE_W-1:0] signal_lag,
  output logic                approx_enable,
  output logic                busy,
  output logic                overrun,
  output state_t              state_dbg
);

  // Approximator handshake: approx_enable is a 1-cycle start pulse; the
  // approximator acknowledges by pulling approx_ready low and signals
  // completion by raising it again. No new sample is taken until then.

  state_t state, state_nxt;

  logic                capture;
  logic                far_done, near_done;
  logic [DOUBLE_W-1:0] far_dbl, near_dbl;
  logic [DELAY_W-1:0]  delay_q;
  logic [DELAY_W-1:0]  wr_ptr;
  logic [DELAY_W-1:0]  rd_idx;
  logic [DELAY_W:0]    fill;
  logic [DOUBLE_W-1:0] lag_val;
  logic [DOUBLE_W-1:0] mem [MAX_DELAY];

  assign capture = (state == ST_IDLE) && sample_valid;

  pcm_to_double #(.PCM_W(PCM_W)) u_far (
    .clk_operation (clk_operation),
    .rst           (rst),
    .start         (capture),
    .pcm           (far_pcm),
    .done          (far_done),
    .result        (far_dbl)
  );

  pcm_to_double #(.PCM_W(PCM_W)) u_near (
    .clk_operation (clk_operation),
    .rst           (rst),
    .start         (capture),
    .pcm           (near_pcm),
    .done          (near_done),
    .result        (near_dbl)
  );

  // delay=0 must return the sample being written this cycle, so bypass the array.
  assign rd_idx = wr_ptr - delay_q;
  always_comb begin
    lag_val = FP_ZERO;
    if ({1'b0, delay_q} > fill) lag_val = FP_ZERO;
    else if (delay_q == '0)     lag_val = near_dbl;
    else                        lag_val = mem[rd_idx];
  end

  always_ff @(posedge clk_operation) begin
    if (state == ST_BUFFER) mem[wr_ptr] <= near_dbl;
  end

  // Outputs load on the edge into PRESENT so they are valid while approx_enable is high.
  always_ff @(posedge clk_operation or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      delay_q    <= '0;
      wr_ptr     <= '0;
      fill       <= '0;
      signal     <= FP_ZERO;
      signal_lag <= FP_ZERO;
      overrun    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) delay_q <= delay;
      if (state == ST_BUFFER) begin
        wr_ptr     <= wr_ptr + DELAY_W'(1);
        signal     <= far_dbl;
        signal_lag <= lag_val;
        if (fill != (DELAY_W + 1)'(MAX_DELAY)) fill <= fill + (DELAY_W + 1)'(1);
      end
      if (sample_valid && (state != ST_IDLE)) overrun <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (sample_valid)            state_nxt = ST_CONVERT;
      ST_CONVERT: if (far_done && near_done)   state_nxt = ST_BUFFER;
      ST_BUFFER:                               state_nxt = ST_PRESENT;
      ST_PRESENT:                              state_nxt = ST_WAIT_LO;
      ST_WAIT_LO: if (!approx_ready)           state_nxt = ST_WAIT_HI;
      ST_WAIT_HI: if (approx_ready)            state_nxt = ST_IDLE;
      default:                                 state_nxt = ST_IDLE;
    endcase
  end

  assign approx_enable = (state == ST_PRESENT);
  assign busy          = (state != ST_IDLE);
  assign state_dbg     = state;

endmodule

// File: tb/tb_echo_sample_frontend.sv
// Self-checking bench for echo_sample_frontend: table-driven conversion vectors,
// alignment/wrap sequences, handshake, overrun and mid-operation reset cases.
module tb_echo_sample_frontend;
  import echo_pkg::*;

  localparam int PCM_W     = 16;
  localparam int MAX_DELAY = 64;
  localparam int DELAY_W   = 6;
  localparam int LAT       = PCM_W + 2;

  logic                clk_operation = 1'b0;
  logic                rst           = 1'b0;
  logic                sample_valid  = 1'b0;
  logic                approx_ready  = 1'b1;
  logic [PCM_W-1:0]    far_pcm       = '0;
  logic [PCM_W-1:0]    near_pcm      = '0;
  logic [DELAY_W-1:0]  delay         = '0;
  logic [DOUBLE_W-1:0] signal, signal_lag;
  logic                approx_enable, busy, overrun;
  state_t              state_dbg;

  echo_sample_frontend #(.PCM_W(PCM_W), .MAX_DELAY(MAX_DELAY), .DELAY_W(DELAY_W)) dut (
    .clk_operation (clk_operation),
    .rst           (rst),
    .sample_valid  (sample_valid),
    .far_pcm       (far_pcm),
    .near_pcm      (near_pcm),
    .delay         (delay),
    .approx_ready  (approx_ready),
    .signal        (signal),
    .signal_lag    (signal_lag),
    .approx_enable (approx_enable),
    .busy          (busy),
    .overrun       (overrun),
    .state_dbg     (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_operation = ~clk_operation;

  int cyc = 0;
  always @(posedge clk_operation) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DOUBLE_W-1:0] exp_q[$];
  logic [DOUBLE_W-1:0] exp_lag_q[$];
  int                  exp_cyc_q[$];

  function automatic logic [63:0] to_dbl(input int v);
    return $realtobits(real'(v));
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_operation) begin
    if (rst && approx_enable) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_enable actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        check64("signal", signal, exp_q.pop_front());
        check64("signal_lag", signal_lag, exp_lag_q.pop_front());
        check64("enable_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_operation);
    #1;
  endtask

  task automatic flush_scoreboard();
    exp_q.delete();
    exp_lag_q.delete();
    exp_cyc_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sample_valid = 1'b0;
    approx_ready = 1'b1;
    flush_scoreboard();
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  // Called at posedge+1; presents a sample for one cycle, optionally scoreboarded.
  task automatic drive_sample(input logic [15:0] f, input logic [15:0] n, input logic [5:0] d,
                              input logic [63:0] e_sig, input logic [63:0] e_lag, input bit push);
    far_pcm = f;
    near_pcm = n;
    delay = d;
    sample_valid = 1'b1;
    if (push) begin
      exp_q.push_back(e_sig);
      exp_lag_q.push_back(e_lag);
      exp_cyc_q.push_back(cyc + LAT);
    end
    tick(1);
    sample_valid = 1'b0;
  endtask

  task automatic wait_enable();
    int n;
    n = 0;
    while (!approx_enable && n < 40) begin
      tick(1);
      n++;
    end
    if (!approx_enable) begin
      checks++;
      errors++;
      $display("FAIL enable_timeout actual=0 expected=1 (cycle %0d)", cyc);
    end
  endtask

  task automatic finish_handshake();
    int n;
    wait_enable();
    approx_ready = 1'b0;
    tick(2);
    approx_ready = 1'b1;
    n = 0;
    while (busy && n < 10) begin
      tick(1);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy expected=idle (cycle %0d)", cyc);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [15:0] far;
    logic [15:0] near;
    logic [5:0]  dly;
    logic [63:0] exp_sig;
    logic [63:0] exp_lag;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [15:0] f;
    vecs[0] = '{16'h0001, 16'h0000, 6'd0,  64'h3FF0000000000000, 64'h0};
    vecs[1] = '{16'h8000, 16'h0001, 6'd0,  64'hC0E0000000000000, 64'h3FF0000000000000};
    vecs[2] = '{16'h7FFF, 16'hFFFF, 6'd0,  64'h40DFFFC000000000, 64'hBFF0000000000000};
    vecs[3] = '{16'hFFFF, 16'h0002, 6'd0,  64'hBFF0000000000000, 64'h4000000000000000};
    vecs[4] = '{16'h0000, 16'h8000, 6'd1,  64'h0,                64'h4000000000000000};
    vecs[5] = '{16'h0003, 16'h0005, 6'd63, 64'h4008000000000000, 64'h0};
    vecs[6] = '{16'h0005, 16'h0007, 6'd2,  64'h4014000000000000, 64'hC0E0000000000000};

    // reset state, observed while reset is held
    #3;
    check64("reset_signal", signal, 64'h0);
    check64("reset_signal_lag", signal_lag, 64'h0);
    check64("reset_enable", 64'(approx_enable), 64'h0);
    check64("reset_busy", 64'(busy), 64'h0);
    check64("reset_overrun", 64'(overrun), 64'h0);
    check64("reset_state", 64'(state_dbg), 64'(ST_IDLE));
    do_reset();

    // conversion and basic alignment table
    for (int i = 0; i < 7; i++) begin
      drive_sample(vecs[i].far, vecs[i].near, vecs[i].dly, vecs[i].exp_sig, vecs[i].exp_lag, 1'b1);
      finish_handshake();
    end

    // delay=3 fill-in from a fresh buffer
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      f = 16'($urandom_range(0, 65535));
      drive_sample(f, 16'(k), 6'd3, to_dbl(int'($signed(f))), (k >= 4) ? to_dbl(k - 3) : 64'h0, 1'b1);
      finish_handshake();
    end

    // delay=63 over 70 samples exercises write-pointer wrap and fill saturation
    do_reset();
    for (int k = 1; k <= 70; k++) begin
      drive_sample(16'(k), 16'(k), 6'd63, to_dbl(k), (k >= 64) ? to_dbl(k - 63) : 64'h0, 1'b1);
      finish_handshake();
    end

    // approx_ready held high keeps the FSM waiting for the acknowledge
    drive_sample(16'hFFFB, 16'h0040, 6'd0, to_dbl(-5), to_dbl(64), 1'b1);
    wait_enable();
    tick(10);
    check64("hold_wait_lo_state", 64'(state_dbg), 64'(ST_WAIT_LO));
    check64("hold_busy", 64'(busy), 64'h1);
    approx_ready = 1'b0;
    tick(1);
    check64("ack_wait_hi_state", 64'(state_dbg), 64'(ST_WAIT_HI));
    approx_ready = 1'b1;
    tick(1);
    check64("done_idle_busy", 64'(busy), 64'h0);
    drive_sample(16'h0002, 16'h0003, 6'd0, to_dbl(2), to_dbl(3), 1'b1);
    finish_handshake();
    check64("no_overrun_yet", 64'(overrun), 64'h0);

    // samples offered while busy are dropped
    drive_sample(16'd100, 16'd200, 6'd0, to_dbl(100), to_dbl(200), 1'b1);
    tick(3);
    drive_sample(16'h1234, 16'h4321, 6'd5, 64'h0, 64'h0, 1'b0);
    check64("overrun_convert", 64'(overrun), 64'h1);
    wait_enable();
    approx_ready = 1'b0;
    tick(2);
    far_pcm = 16'h5555;
    near_pcm = 16'h6666;
    sample_valid = 1'b1;
    tick(1);
    approx_ready = 1'b1;
    tick(1);
    sample_valid = 1'b0;
    check64("exit_same_cycle_idle", 64'(busy), 64'h0);
    tick(30);
    check64("dropped_signal", signal, to_dbl(100));
    check64("dropped_signal_lag", signal_lag, to_dbl(200));
    check64("dropped_busy", 64'(busy), 64'h0);
    check64("overrun_sticky", 64'(overrun), 64'h1);

    // reset in the middle of a conversion
    drive_sample(16'd9, 16'd11, 6'd0, to_dbl(9), to_dbl(11), 1'b1);
    tick(5);
    #2;
    rst = 1'b0;
    flush_scoreboard();
    #1;
    check64("midreset_signal", signal, 64'h0);
    check64("midreset_signal_lag", signal_lag, 64'h0);
    check64("midreset_enable", 64'(approx_enable), 64'h0);
    check64("midreset_busy", 64'(busy), 64'h0);
    check64("midreset_overrun", 64'(overrun), 64'h0);
    tick(2);
    rst = 1'b1;
    tick(1);
    drive_sample(vecs[0].far, vecs[0].near, vecs[0].dly, vecs[0].exp_sig, vecs[0].exp_lag, 1'b1);
    finish_handshake();

    tick(5);
    check64("pending_expectations", 64'(exp_q.size()), 64'h0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
